ram_dp_be: RTL and testbench

- Parametrised successor to the single-port RAM: one read/write port A with byte enables, plus one independent read-only port B.
- Read-during-write mode is selected by parameter instead of source-level macro.
- Optional post-reset clear sweep; optional per-byte parity.
- Sits between the CPU bus (port A) and peripheral scanners such as VGA/segment refresh (port B).

---
 rtl/ram_dp_be_pkg.sv | 26 ++
 rtl/ram_byte_merge.sv | 49 ++++
 rtl/ram_dp_be.sv | 175 +++++++++++++++++
 tb/tb_ram_dp_be.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_dp_be_pkg.sv
// ---------------------------------------------------------------------------
// ram_dp_be_pkg : read-mode and clear-FSM encodings, byte parity helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ram_dp_be_pkg;

  localparam int RAM_MODE_NORMAL      = 0;
  localparam int RAM_MODE_WRITE_FIRST = 1;
  localparam int RAM_MODE_READ_FIRST  = 2;
  localparam int RAM_MODE_NO_CHANGE   = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Even parity: stored bit makes the 9-bit lane have an even number of ones.
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_byte_merge.sv
// ---------------------------------------------------------------------------
// ram_byte_merge : merges old/new words by byte enable; parity gen/check when RAM_PARITY_EN
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_byte_merge
  import ram_dp_be_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NB    = WIDTH / 8
) (
  input  logic [WIDTH-1:0] old_i,
  input  logic [WIDTH-1:0] new_i,
  input  logic [NB-1:0]    wena_i,
  output logic [WIDTH-1:0] merged_o
`ifdef RAM_PARITY_EN
  ,
  input  logic [NB-1:0]    old_par_i,
  output logic [NB-1:0]    merged_par_o,
  output logic             old_perr_o,
  output logic             merged_perr_o
`endif
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < NB; i++) begin
      if (wena_i[i]) merged_o[8*i +: 8] = new_i[8*i +: 8];
    end
  end

`ifdef RAM_PARITY_EN
  // Unwritten lanes keep their stored parity so an existing fault stays visible.
  always_comb begin
    merged_par_o  = old_par_i;
    old_perr_o    = 1'b0;
    merged_perr_o = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (wena_i[i]) merged_par_o[i] = even_par(new_i[8*i +: 8]);
      old_perr_o    = old_perr_o    | (even_par(old_i[8*i +: 8])    != old_par_i[i]);
      merged_perr_o = merged_perr_o | (even_par(merged_o[8*i +: 8]) != merged_par_o[i]);
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/ram_dp_be.sv
// ---------------------------------------------------------------------------
// ram_dp_be : RW byte-enable port A + read-only port B RAM, clear sweep; parity via RAM_PARITY_EN
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_dp_be
  import ram_dp_be_pkg::*;
#(
  parameter int    WIDTH          = 32,
  parameter int    DEPTH          = 10,
  parameter int    MODE           = 0,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = "none"
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               busy,
  input  logic               a_ena,
  input  logic [WIDTH/8-1:0] a_wena,
  input  logic [DEPTH-1:0]   a_addr,
  input  logic [WIDTH-1:0]   a_din,
  output logic [WIDTH-1:0]   a_dout,
  input  logic               b_ena,
  input  logic [DEPTH-1:0]   b_addr,
  output logic [WIDTH-1:0]   b_dout,
  output logic               a_perr,
  output logic               b_perr
);

  localparam int NB    = WIDTH / 8;
  localparam int WORDS = 2 ** DEPTH;

  logic [WIDTH-1:0] ram_q [WORDS];
  clr_state_e       state_q;
  logic [DEPTH-1:0] clr_addr_q;

  logic [WIDTH-1:0] rd_a, rd_b, merged;
  logic             wr_user;
  logic             a_perr_rd, a_perr_mrg, b_perr_rd;

  assign busy    = (state_q == ST_CLEAR);
  assign wr_user = !busy && a_ena && (|a_wena);
  assign rd_a    = ram_q[a_addr];
  assign rd_b    = ram_q[b_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_addr_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_addr_q <= clr_addr_q + 1'b1;
      if (&clr_addr_q) state_q <= ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (busy)         ram_q[clr_addr_q] <= '0;
    else if (wr_user) ram_q[a_addr]     <= merged;
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par_q [WORDS];
  logic [NB-1:0] merged_par;
  logic [NB-1:0] rd_b_par;

  ram_byte_merge #(.WIDTH(WIDTH), .NB(NB)) u_merge (
    .old_i         (rd_a),
    .new_i         (a_din),
    .wena_i        (a_wena),
    .merged_o      (merged),
    .old_par_i     (par_q[a_addr]),
    .merged_par_o  (merged_par),
    .old_perr_o    (a_perr_rd),
    .merged_perr_o (a_perr_mrg)
  );

  // Parity of an all-zero lane is zero, so the sweep clears parity too.
  always_ff @(posedge clk) begin
    if (busy)         par_q[clr_addr_q] <= '0;
    else if (wr_user) par_q[a_addr]     <= merged_par;
  end

  assign rd_b_par = par_q[b_addr];

  always_comb begin
    b_perr_rd = 1'b0;
    for (int i = 0; i < NB; i++) begin
      b_perr_rd = b_perr_rd | (even_par(rd_b[8*i +: 8]) != rd_b_par[i]);
    end
  end
`else
  ram_byte_merge #(.WIDTH(WIDTH), .NB(NB)) u_merge (
    .old_i    (rd_a),
    .new_i    (a_din),
    .wena_i   (a_wena),
    .merged_o (merged)
  );

  assign a_perr_rd  = 1'b0;
  assign a_perr_mrg = 1'b0;
  assign b_perr_rd  = 1'b0;
`endif

  generate
    if (MODE == RAM_MODE_NORMAL) begin : g_rd_comb
      assign a_dout = busy ? '0 : rd_a;
      assign b_dout = busy ? '0 : rd_b;
      assign a_perr = !busy && a_perr_rd;
      assign b_perr = !busy && b_perr_rd;
    end else begin : g_rd_reg
      logic [WIDTH-1:0] a_dout_q, a_dout_d, b_dout_q, b_dout_d;
      logic             a_perr_q, a_perr_d, b_perr_q, b_perr_d;

      // Port B always samples the pre-write word, so collisions return old data.
      always_comb begin
        a_dout_d = a_dout_q;
        a_perr_d = a_perr_q;
        b_dout_d = b_dout_q;
        b_perr_d = b_perr_q;
        if (busy) begin
          a_dout_d = '0;
          a_perr_d = 1'b0;
          b_dout_d = '0;
          b_perr_d = 1'b0;
        end else begin
          if (a_ena) begin
            case (MODE)
              RAM_MODE_WRITE_FIRST: begin
                a_dout_d = merged;
                a_perr_d = a_perr_mrg;
              end
              RAM_MODE_READ_FIRST: begin
                a_dout_d = rd_a;
                a_perr_d = a_perr_rd;
              end
              default: begin
                if (a_wena == '0) begin
                  a_dout_d = rd_a;
                  a_perr_d = a_perr_rd;
                end
              end
            endcase
          end
          if (b_ena) begin
            b_dout_d = rd_b;
            b_perr_d = b_perr_rd;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_dout_q <= '0;
          a_perr_q <= 1'b0;
          b_dout_q <= '0;
          b_perr_q <= 1'b0;
        end else begin
          a_dout_q <= a_dout_d;
          a_perr_q <= a_perr_d;
          b_dout_q <= b_dout_d;
          b_perr_q <= b_perr_d;
        end
      end

      assign a_dout = a_dout_q;
      assign b_dout = b_dout_q;
      assign a_perr = a_perr_q;
      assign b_perr = b_perr_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_be.sv
// ---------------------------------------------------------------------------
// tb_ram_dp_be : one DUT per read mode on shared stimulus, vector table + random vs array model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_dp_be;

  localparam int W     = 32;
  localparam int D     = 4;
  localparam int WORDS = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_ena, b_ena;
  logic [3:0]    a_wena;
  logic [D-1:0]  a_addr, b_addr;
  logic [W-1:0]  a_din;

  logic [W-1:0]  a_dout_w [4];
  logic [W-1:0]  b_dout_w [4];
  logic          busy_w   [4];
  logic          a_perr_w [4];
  logic          b_perr_w [4];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    ram_dp_be #(
      .WIDTH(W), .DEPTH(D), .MODE(m), .CLEAR_ON_RESET(1), .INIT_FILE("none")
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .busy   (busy_w[m]),
      .a_ena  (a_ena),
      .a_wena (a_wena),
      .a_addr (a_addr),
      .a_din  (a_din),
      .a_dout (a_dout_w[m]),
      .b_ena  (b_ena),
      .b_addr (b_addr),
      .b_dout (b_dout_w[m]),
      .a_perr (a_perr_w[m]),
      .b_perr (b_perr_w[m])
    );
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain word array plus the value each registered port last returned.
  logic [W-1:0] mem  [WORDS];
  logic [W-1:0] areg [4];
  logic [W-1:0] breg;
  int           sweep;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic ae, input logic [3:0] we, input logic [D-1:0] aa,
                        input logic [W-1:0] din, input logic be, input logic [D-1:0] ba);
    a_ena = ae; a_wena = we; a_addr = aa; a_din = din; b_ena = be; b_addr = ba;
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    #3;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("rst busy m%0d", m), W'(busy_w[m]), W'(1));
      chk($sformatf("rst a_dout m%0d", m), a_dout_w[m], '0);
      chk($sformatf("rst b_dout m%0d", m), b_dout_w[m], '0);
    end
    sweep = 0;
    for (int m = 0; m < 4; m++) areg[m] = '0;
    breg = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    logic [W-1:0] old_a, old_b, mrg, ea0, eb0;
    logic         bz;
    @(posedge clk);
    if (sweep < WORDS) begin
      sweep++;
      if (sweep == WORDS) for (int i = 0; i < WORDS; i++) mem[i] = '0;
      for (int m = 0; m < 4; m++) areg[m] = '0;
      breg = '0;
    end else begin
      old_a = mem[a_addr];
      old_b = mem[b_addr];
      for (int i = 0; i < 4; i++) mrg[8*i +: 8] = a_wena[i] ? a_din[8*i +: 8] : old_a[8*i +: 8];
      if (a_ena) begin
        areg[1] = mrg;
        areg[2] = old_a;
        if (a_wena == 4'b0) areg[3] = old_a;
        else                mem[a_addr] = mrg;
      end
      if (b_ena) breg = old_b;
    end
    #1;
    bz  = (sweep < WORDS);
    ea0 = bz ? '0 : mem[a_addr];
    eb0 = bz ? '0 : mem[b_addr];
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("busy m%0d", m), W'(busy_w[m]), W'(bz));
      chk($sformatf("a_dout m%0d", m), a_dout_w[m], (m == 0) ? ea0 : areg[m]);
      chk($sformatf("b_dout m%0d", m), b_dout_w[m], (m == 0) ? eb0 : breg);
      chk($sformatf("a_perr m%0d", m), W'(a_perr_w[m]), '0);
      chk($sformatf("b_perr m%0d", m), W'(b_perr_w[m]), '0);
    end
  endtask

  typedef struct {
    logic         ae;
    logic [3:0]   we;
    logic [D-1:0] aa;
    logic [W-1:0] din;
    logic         be;
    logic [D-1:0] ba;
    logic [W-1:0] e_a1, e_a2, e_a3, e_b;
  } vec_t;

  vec_t vt [8];

  initial begin
    int n;
    vt[0] = '{1'b1, 4'hF, 4'd3, 32'hA5A5A5A5, 1'b1, 4'd3, 32'hA5A5A5A5, 32'h0,        32'h0,        32'h0};
    vt[1] = '{1'b1, 4'h5, 4'd3, 32'h11223344, 1'b1, 4'd3, 32'hA522A544, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5};
    vt[2] = '{1'b1, 4'h0, 4'd3, 32'h0,        1'b1, 4'd3, 32'hA522A544, 32'hA522A544, 32'hA522A544, 32'hA522A544};
    vt[3] = '{1'b1, 4'hF, 4'd5, 32'h0,        1'b0, 4'd0, 32'h0,        32'h0,        32'hA522A544, 32'hA522A544};
    vt[4] = '{1'b0, 4'hF, 4'd5, 32'h12345678, 1'b1, 4'd7, 32'h0,        32'h0,        32'hA522A544, 32'h0};
    vt[5] = '{1'b1, 4'hF, 4'd7, 32'hDEADBEEF, 1'b1, 4'd7, 32'hDEADBEEF, 32'h0,        32'hA522A544, 32'h0};
    vt[6] = '{1'b1, 4'h0, 4'd5, 32'h0,        1'b1, 4'd7, 32'h0,        32'h0,        32'h0,        32'hDEADBEEF};
    vt[7] = '{1'b1, 4'h0, 4'd7, 32'h0,        1'b0, 4'd7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};

    for (int i = 0; i < WORDS; i++) mem[i] = '0;
    set_in(1'b0, 4'h0, '0, '0, 1'b0, '0);
    rst_n = 1'b1;
    #2;
    hard_reset();
    for (int k = 0; k < WORDS; k++) step();

    // Fill the array with all-ones so the later sweep has something to clear.
    for (int i = 0; i < WORDS; i++) begin
      set_in(1'b1, 4'hF, D'(i), 32'hFFFFFFFF, 1'b1, D'(i));
      step();
    end

    // Sweep with user writes attempted (must be ignored), interrupted at cycle 9.
    hard_reset();
    for (int k = 0; k < 9; k++) begin
      set_in(1'b1, 4'hF, D'(k), 32'hFFFFFFFF, 1'b1, D'(k));
      step();
    end
    hard_reset();
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      set_in(1'b1, 4'hF, D'(k), 32'hFFFFFFFF, 1'b1, D'(k));
      step();
      n = k;
      if (!busy_w[0]) break;
    end
    chk("busy length", W'(n), W'(16));

    for (int i = 0; i < WORDS; i++) begin
      set_in(1'b1, 4'h0, D'(i), '0, 1'b1, D'(WORDS - 1 - i));
      step();
      chk("cleared a", a_dout_w[0], '0);
      chk("cleared b", b_dout_w[0], '0);
    end

    for (int i = 0; i < 8; i++) begin
      set_in(vt[i].ae, vt[i].we, vt[i].aa, vt[i].din, vt[i].be, vt[i].ba);
      step();
      chk($sformatf("vec%0d a WF", i), a_dout_w[1], vt[i].e_a1);
      chk($sformatf("vec%0d a RF", i), a_dout_w[2], vt[i].e_a2);
      chk($sformatf("vec%0d a NC", i), a_dout_w[3], vt[i].e_a3);
      for (int m = 1; m < 4; m++) chk($sformatf("vec%0d b m%0d", i, m), b_dout_w[m], vt[i].e_b);
    end

    for (int k = 0; k < 400; k++) begin
      set_in(1'($urandom), 4'($urandom), D'($urandom), $urandom, 1'($urandom), D'($urandom));
      step();
    end

`ifdef RAM_PARITY_EN
    set_in(1'b0, 4'h0, 4'd2, '0, 1'b0, 4'd2);
    g_dut[0].u_dut.ram_q[2] = g_dut[0].u_dut.ram_q[2] ^ 32'h1;
    #1;
    chk("perr a addr2", W'(a_perr_w[0]), W'(1));
    chk("perr b addr2", W'(b_perr_w[0]), W'(1));
    a_addr = 4'd3;
    b_addr = 4'd4;
    #1;
    chk("perr a addr3", W'(a_perr_w[0]), W'(0));
    chk("perr b addr4", W'(b_perr_w[0]), W'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

`default_nettype wire
